// File: rtl/alu_ctrl_pkg.sv
// Shared types and defaults for the shared adder/subtractor controller.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic pointer;

  always_ff @(posedge clk) begin
    if (rst) begin
      pointer <= 1'b0;
    end else if (advance) begin
      // hand priority to whichever port did not win this time
      pointer <= grant[0];
    end
  end

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external add/sub unit between two requesters with round-robin
// arbitration, a bounded wait for the adder's done flag and a one-cycle response.
//
// state | meaning
// IDLE  | arbitrate, accept one request
// ISSUE | adder settles on new operands, done ignored
// WAIT  | wait for add_done or timeout
// RESP  | one-cycle response pulse to the owner
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_mode,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [1:0]       grant;
  logic             accept;
  logic             owner;
  logic [CW-1:0]    cnt;
  logic             timed_out;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_err;

  assign accept    = (state == IDLE) && (grant != 2'b00);
  assign timed_out = (cnt == CNT_LAST);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (add_done || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_x    <= '0;
      add_y    <= '0;
      add_mode <= MODE_ADD;
      owner    <= 1'b0;
      cnt      <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        add_x    <= grant[1] ? req1_a    : req0_a;
        add_y    <= grant[1] ? req1_b    : req0_b;
        add_mode <= grant[1] ? req1_mode : req0_mode;
        owner    <= grant[1];
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        // done wins over timeout when both land on the final cycle
        if (add_done) begin
          res_sum  <= add_sum;
          res_cout <= add_cout;
          res_err  <= 1'b0;
        end else if (timed_out) begin
          res_sum  <= '0;
          res_cout <= 1'b0;
          res_err  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    req0_ready = (state == IDLE) && grant[0];
    req1_ready = (state == IDLE) && grant[1];
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) && owner;
    rsp0_sum   = res_sum;
    rsp0_cout  = res_cout;
    rsp0_err   = res_err;
    rsp1_sum   = res_sum;
    rsp1_cout  = res_cout;
    rsp1_err   = res_err;
  end

endmodule
